// File: rtl/ov7670_frame_capture.sv
// OV7670 frame capture: assembles RGB565 pixels from the camera byte stream,
// decimates 2:1 in both axes and writes the kept pixels into a frame buffer.
//
// Ports:
//   clk, reset      single clock; asynchronous active-high reset
//   cam_vsync       frame sync, high between frames
//   cam_href        line valid
//   cam_byte_valid  cam_data carries a new byte this cycle
//   cam_data        camera byte
//   wr_en           one-cycle frame-buffer write strobe
//   wr_addr         IMG_WIDTH*y + x of the stored pixel (held when idle)
//   wr_data         RGB565 pixel (held when idle)
//   frame_done      one-cycle pulse when a captured frame ends
//   frame_err       line count of the last completed frame was not SRC_HEIGHT
//
// Build option: define CAPTURE_BYTE_SWAP_EN to place the first byte of each
// pixel in wr_data[7:0] and the second in wr_data[15:8].
module ov7670_frame_capture #(
    parameter int SRC_WIDTH  = 320,
    parameter int SRC_HEIGHT = 240,
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic                  cam_byte_valid,
    input  logic [7:0]            cam_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int XW = $clog2(SRC_WIDTH + 1);
    localparam int YW = $clog2(SRC_HEIGHT + 1);

    localparam logic [XW-1:0]         SW = XW'(SRC_WIDTH);
    localparam logic [YW-1:0]         SH = YW'(SRC_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] IW = ADDR_WIDTH'(IMG_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        CAPTURE
    } state_t;

    state_t          state;
    logic            vsync_q;
    logic            href_q;
    logic [XW-1:0]   src_x;
    logic [YW-1:0]   src_y;
    logic            phase;
    logic [7:0]      byte_hi;

    logic            vsync_rise;
    logic            vsync_fall;
    logic            href_fall;
    logic            accept;
    logic            keep;
    logic [YW-1:0]   y_inc;
    logic [YW-1:0]   y_next;
    logic [15:0]     pix_word;
    logic [ADDR_WIDTH-1:0] pix_addr;

    always_comb begin
        vsync_rise = cam_vsync & ~vsync_q;
        vsync_fall = ~cam_vsync & vsync_q;
        href_fall  = ~cam_href & href_q;
        accept     = cam_href & cam_byte_valid;
        // Only even columns of even rows inside the source window are kept,
        // which also bounds the address to IMG_WIDTH*IMG_HEIGHT-1.
        keep       = ~src_x[0] & ~src_y[0] & (src_x < SW) & (src_y < SH);
        y_inc      = (src_y < SH) ? src_y + YW'(1) : src_y;
        // Frame error must see a line end landing on the same cycle.
        y_next     = href_fall ? y_inc : src_y;
`ifdef CAPTURE_BYTE_SWAP_EN
        pix_word   = {cam_data, byte_hi};
`else
        pix_word   = {byte_hi, cam_data};
`endif
        pix_addr   = ADDR_WIDTH'(src_y[YW-1:1]) * IW
                   + ADDR_WIDTH'(src_x[XW-1:1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            src_x      <= '0;
            src_y      <= '0;
            phase      <= 1'b0;
            byte_hi    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            vsync_q    <= cam_vsync;
            href_q     <= cam_href;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A high vsync must be seen before any falling edge
                    // can start a capture.
                    if (cam_vsync)
                        state <= WAIT_START;
                end
                WAIT_START: begin
                    if (vsync_fall) begin
                        state <= CAPTURE;
                        src_x <= '0;
                        src_y <= '0;
                        phase <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (href_fall) begin
                        // A dangling first byte of a pixel is dropped here.
                        src_x <= '0;
                        phase <= 1'b0;
                        src_y <= y_inc;
                    end else if (accept) begin
                        if (!phase) begin
                            byte_hi <= cam_data;
                            phase   <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (keep) begin
                                wr_en   <= 1'b1;
                                wr_addr <= pix_addr;
                                wr_data <= pix_word;
                            end
                            if (src_x < SW)
                                src_x <= src_x + XW'(1);
                        end
                    end
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        frame_err  <= (y_next != SH);
                        state      <= WAIT_START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Self-checking bench for ov7670_frame_capture on a reduced 40x30 source.
// Line/frame-level model feeds expected writes and frame ends to a checker.
module tb_ov7670_frame_capture;

    localparam int SW = 40;
    localparam int SH = 30;
    localparam int IW = 20;
    localparam int IH = 15;
    localparam int AW = $clog2(IW * IH);

`ifdef CAPTURE_BYTE_SWAP_EN
    localparam logic [15:0] EXP_F800 = 16'h00F8;
    localparam logic [15:0] EXP_1234 = 16'h3412;
`else
    localparam logic [15:0] EXP_F800 = 16'hF800;
    localparam logic [15:0] EXP_1234 = 16'h1234;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vs = 1'b0;
    logic          hr = 1'b0;
    logic          bv = 1'b0;
    logic [7:0]    d = 8'h00;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          frame_done;
    logic          frame_err;

    ov7670_frame_capture #(
        .SRC_WIDTH (SW),
        .SRC_HEIGHT(SH),
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cam_vsync     (vs),
        .cam_href      (hr),
        .cam_byte_valid(bv),
        .cam_data      (d),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_done    (frame_done),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   dt;
    } wr_t;

    wr_t           wq[$];
    bit            dq[$];
    wr_t           ce;
    bit            cerr;
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_wr = 0;
    int            n_done = 0;
    logic [AW-1:0] last_addr = '0;
    logic [15:0]   last_data = '0;
    logic          last_err = 1'b0;
    logic [AW-1:0] obs_addr = '0;
    logic [15:0]   obs_data = '0;
    bit            m_capt = 0;
    int            m_y = 0;
    bit            vs_level = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // Checker: every cycle, writes and frame ends must match the model.
    always begin
        @(posedge clk);
        #1;
        if (wr_en) begin
            n_wr++;
            obs_addr = wr_addr;
            obs_data = wr_data;
            if (wq.size() == 0) begin
                chk("spurious_wr", 32'(wr_en), 0);
            end else begin
                ce = wq.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(ce.a));
                chk("wr_data", 32'(wr_data), 32'(ce.dt));
                last_addr = ce.a;
                last_data = ce.dt;
            end
        end else begin
            chk("hold_addr", 32'(wr_addr), 32'(last_addr));
            chk("hold_data", 32'(wr_data), 32'(last_data));
        end
        if (frame_done) begin
            n_done++;
            if (dq.size() == 0) begin
                chk("spurious_done", 32'(frame_done), 0);
            end else begin
                cerr = dq.pop_front();
                last_err = cerr;
            end
        end
        chk("frame_err", 32'(frame_err), 32'(last_err));
    end

    task automatic drive(input logic v, input logic h, input logic b,
                         input logic [7:0] dd);
        @(negedge clk);
        vs = v;
        hr = h;
        bv = b;
        d  = dd;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(vs_level, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic push_pixel(input int x, input logic [7:0] b0,
                              input logic [7:0] b1);
        wr_t e;
        if (m_capt && x % 2 == 0 && m_y % 2 == 0 && x < SW && m_y < SH) begin
            e.a = AW'((m_y / 2) * IW + x / 2);
`ifdef CAPTURE_BYTE_SWAP_EN
            e.dt = {b1, b0};
`else
            e.dt = {b0, b1};
`endif
            wq.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        vs = 1'b0;
        hr = 1'b0;
        bv = 1'b0;
        vs_level = 0;
        #1;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_done", 32'(frame_done), 0);
        wq.delete();
        dq.delete();
        m_capt = 0;
        m_y = 0;
        last_addr = '0;
        last_data = '0;
        last_err = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // pat: 0 = 0xF800, 1 = {y, x>>1}, 2 = random, 3 = 0x1234 then random
    task automatic send_line(input int nbytes, input int pat,
                             input bit vs_end, input int abort_b);
        logic [15:0] v;
        int x;
        v = '0;
        for (int b = 0; b < nbytes; b++) begin
            if (b == abort_b) begin
                do_reset();
                return;
            end
            if (b % 5 == 3)
                drive(1'b0, 1'b1, 1'b0, 8'($urandom));
            x = b / 2;
            if (b % 2 == 0) begin
                case (pat)
                    0:       v = 16'hF800;
                    1:       v = {8'(m_y), 8'(x >> 1)};
                    3:       v = (x == 0) ? 16'h1234 : 16'($urandom);
                    default: v = 16'($urandom);
                endcase
                drive(1'b0, 1'b1, 1'b1, v[15:8]);
            end else begin
                drive(1'b0, 1'b1, 1'b1, v[7:0]);
                push_pixel(x, v[15:8], v[7:0]);
            end
        end
        drive(vs_end, 1'b0, 1'b0, 8'h00);
        if (m_capt) begin
            if (m_y < SH)
                m_y = m_y + 1;
            if (vs_end) begin
                dq.push_back(m_y != SH);
                m_capt = 0;
            end
        end
        vs_level = vs_end;
        idle(2);
    endtask

    task automatic end_frame();
        if (!vs_level) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            if (m_capt) begin
                dq.push_back(m_y != SH);
                m_capt = 0;
            end
            vs_level = 1;
        end
        idle(3);
    endtask

    task automatic start_frame();
        end_frame();
        vs_level = 0;
        idle(1);
        m_capt = 1;
        m_y = 0;
        idle(1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_addr", 32'(wr_addr), 0);
        chk("reset_data", 32'(wr_data), 0);
        chk("reset_done", 32'(frame_done), 0);
        chk("reset_err", 32'(frame_err), 0);
        reset = 1'b0;

        // No capture before a full vsync pulse
        send_line(2 * SW, 0, 0, -1);
        chk("no_cap_before_vsync", 32'(n_wr), 0);

        // Frame 1: first line constant, last href fall meets vsync rise
        start_frame();
        send_line(2 * SW, 0, 0, -1);
        idle(2);
        chk("line0_writes", 32'(n_wr), 20);
        chk("line0_last_addr", 32'(obs_addr), 19);
        chk("line0_data", 32'(obs_data), 32'(EXP_F800));
        for (int y = 1; y < SH; y++)
            send_line(2 * SW, 1, y == SH - 1, -1);
        idle(3);
        chk("f1_done", 32'(n_done), 1);
        chk("f1_err", 32'(frame_err), 0);
        chk("f1_writes", 32'(n_wr), 300);
        chk("f1_last_addr", 32'(obs_addr), 299);

        // Frame 2: full frame, normal end
        start_frame();
        for (int y = 0; y < SH; y++)
            send_line(2 * SW, 1, 0, -1);
        end_frame();
        chk("f2_done", 32'(n_done), 2);
        chk("f2_err", 32'(frame_err), 0);
        chk("f2_writes", 32'(n_wr), 600);

        // Frame 3: one line short
        start_frame();
        for (int y = 0; y < SH - 1; y++)
            send_line(2 * SW, 2, 0, -1);
        end_frame();
        chk("f3_done", 32'(n_done), 3);
        chk("f3_err", 32'(frame_err), 1);
        chk("f3_writes", 32'(n_wr), 900);

        // Frame 4: odd-length and over-width lines
        start_frame();
        for (int y = 0; y < SH; y++)
            send_line((y == 2) ? 2 * SW + 1 : (y == 6) ? 2 * SW + 6 : 2 * SW,
                      2, 0, -1);
        end_frame();
        chk("f4_done", 32'(n_done), 4);
        chk("f4_err", 32'(frame_err), 0);
        chk("f4_writes", 32'(n_wr), 1200);

        // Frame 5: reset at pixel 10 of line 6
        start_frame();
        for (int y = 0; y < 6; y++)
            send_line(2 * SW, 1, 0, -1);
        send_line(2 * SW, 1, 0, 20);
        idle(3);
        chk("abort_writes", 32'(n_wr), 1265);
        chk("abort_no_done", 32'(n_done), 4);
        send_line(2 * SW, 1, 0, -1);
        chk("post_reset_no_wr", 32'(n_wr), 1265);

        // Byte order after a fresh vsync pulse
        start_frame();
        send_line(2, 3, 0, -1);
        idle(2);
        chk("byte_order", 32'(obs_data), 32'(EXP_1234));
        chk("byte_order_addr", 32'(obs_addr), 0);
        chk("byte_order_writes", 32'(n_wr), 1266);
        end_frame();
        chk("short_done", 32'(n_done), 5);
        chk("short_err", 32'(frame_err), 1);

        idle(4);
        chk("wq_empty", 32'(wq.size()), 0);
        chk("dq_empty", 32'(dq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
